// File: rtl/snn_ff_pkg.sv
// rtl/snn_ff_pkg.sv - shared encoder FSM states, event VIRTS codes and LFSR taps
package snn_ff_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_EVAL,
        ST_PUSH,
        ST_NEXT,
        ST_WAIT
    } enc_state_t;

    localparam logic [1:0]  EVT_VIRTS_EXT = 2'b00;
    // Galois right-shift form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Galois LFSR with synchronous load and step enable
module lfsr16
    import snn_ff_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        load,
    input  logic        enable,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q <= SEED;
        end else if (load) begin
            q <= seed;
        end else if (enable) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/input_spike_encoder.sv
// rtl/input_spike_encoder.sv - rate-codes pixel memory into AER events for the scheduler
module input_spike_encoder
    import snn_ff_pkg::*;
#(
    parameter int          TIME_STEP           = 8,
    parameter int          INPUT_NEURON        = 784,
    parameter int          PRE_NEUR_ADDR_WIDTH = 10,
    parameter int          PRE_NEUR_DATA_WIDTH = 8,
    parameter logic [15:0] LFSR_SEED           = 16'hACE1,
    localparam int         STEP_W              = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           ENC_START,
    input  logic                           CORE_STEP_READY,
    output logic                           ENC_MEM_CS,
    output logic [PRE_NEUR_ADDR_WIDTH-1:0] ENC_MEM_ADDR,
    input  logic [PRE_NEUR_DATA_WIDTH-1:0] ENC_MEM_DATA,
    input  logic                           SCHED_FULL,
    output logic                           CTRL_SCHED_EVENT_IN,
    output logic [1:0]                     CTRL_SCHED_VIRTS,
    output logic [PRE_NEUR_ADDR_WIDTH-1:0] CTRL_SCHED_ADDR,
    output logic                           ENC_BUSY,
    output logic                           ENC_STEP_DONE,
    output logic                           ENC_DONE,
    output logic [STEP_W-1:0]              ENC_STEP
);

    localparam logic [PRE_NEUR_ADDR_WIDTH-1:0] LAST_ADDR = PRE_NEUR_ADDR_WIDTH'(INPUT_NEURON - 1);
    localparam logic [STEP_W-1:0]              LAST_STEP = STEP_W'(TIME_STEP - 1);

    enc_state_t                     state;
    logic [PRE_NEUR_ADDR_WIDTH-1:0] addr;
    logic [15:0]                    lfsr_q;
    logic                           start_ok;
    logic                           hit;
    logic                           unused_lfsr_hi;

    // A start landing on the final DONE pulse is dropped so a finished image never auto-restarts
    assign start_ok       = (state == ST_IDLE) && ENC_START && !ENC_DONE;
    assign hit            = ENC_MEM_DATA > PRE_NEUR_DATA_WIDTH'(lfsr_q[7:0]);
    assign unused_lfsr_hi = ^lfsr_q[15:8];

    assign CTRL_SCHED_VIRTS = EVT_VIRTS_EXT;

    lfsr16 #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .CLK    (CLK),
        .RST    (RST),
        .load   (start_ok),
        .enable (state == ST_EVAL),
        .seed   (LFSR_SEED),
        .q      (lfsr_q)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state               <= ST_IDLE;
            addr                <= '0;
            ENC_MEM_CS          <= 1'b0;
            ENC_MEM_ADDR        <= '0;
            CTRL_SCHED_EVENT_IN <= 1'b0;
            CTRL_SCHED_ADDR     <= '0;
            ENC_BUSY            <= 1'b0;
            ENC_STEP_DONE       <= 1'b0;
            ENC_DONE            <= 1'b0;
            ENC_STEP            <= '0;
        end else begin
            ENC_MEM_CS          <= 1'b0;
            CTRL_SCHED_EVENT_IN <= 1'b0;
            ENC_STEP_DONE       <= 1'b0;
            ENC_DONE            <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state        <= ST_RD;
                        addr         <= '0;
                        ENC_STEP     <= '0;
                        ENC_BUSY     <= 1'b1;
                        ENC_MEM_CS   <= 1'b1;
                        ENC_MEM_ADDR <= '0;
                    end
                end
                ST_RD: begin
                    state <= ST_EVAL;
                end
                ST_EVAL: begin
                    state <= hit ? ST_PUSH : ST_NEXT;
                end
                ST_PUSH: begin
                    if (!SCHED_FULL) begin
                        CTRL_SCHED_EVENT_IN <= 1'b1;
                        CTRL_SCHED_ADDR     <= addr;
                        state               <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (addr == LAST_ADDR) begin
                        ENC_STEP_DONE <= 1'b1;
                        state         <= ST_WAIT;
                    end else begin
                        addr         <= addr + 1'b1;
                        ENC_MEM_CS   <= 1'b1;
                        ENC_MEM_ADDR <= addr + 1'b1;
                        state        <= ST_RD;
                    end
                end
                ST_WAIT: begin
                    if (CORE_STEP_READY) begin
                        if (ENC_STEP == LAST_STEP) begin
                            ENC_DONE <= 1'b1;
                            ENC_BUSY <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            ENC_STEP     <= ENC_STEP + 1'b1;
                            addr         <= '0;
                            ENC_MEM_CS   <= 1'b1;
                            ENC_MEM_ADDR <= '0;
                            state        <= ST_RD;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_spike_encoder.sv
// tb/tb_input_spike_encoder.sv - scoreboard bench for input_spike_encoder
module tb_input_spike_encoder;

    localparam int TS = 2;
    localparam int NP = 784;
    localparam int AW = 10;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          ENC_START = 1'b0;
    logic          CORE_STEP_READY = 1'b1;
    logic          ENC_MEM_CS;
    logic [AW-1:0] ENC_MEM_ADDR;
    logic [7:0]    ENC_MEM_DATA = '0;
    logic          SCHED_FULL = 1'b0;
    logic          CTRL_SCHED_EVENT_IN;
    logic [1:0]    CTRL_SCHED_VIRTS;
    logic [AW-1:0] CTRL_SCHED_ADDR;
    logic          ENC_BUSY;
    logic          ENC_STEP_DONE;
    logic          ENC_DONE;
    logic [0:0]    ENC_STEP;

    logic [7:0] mem [0:NP-1];
    int         exp_q[$];
    int         n_compared = 0;
    int         n_mismatched = 0;
    int         step_cnt = 0;
    int         done_cnt = 0;
    int         busy_cnt;

    input_spike_encoder #(
        .TIME_STEP           (TS),
        .INPUT_NEURON        (NP),
        .PRE_NEUR_ADDR_WIDTH (AW),
        .PRE_NEUR_DATA_WIDTH (8),
        .LFSR_SEED           (16'hACE1)
    ) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .ENC_START           (ENC_START),
        .CORE_STEP_READY     (CORE_STEP_READY),
        .ENC_MEM_CS          (ENC_MEM_CS),
        .ENC_MEM_ADDR        (ENC_MEM_ADDR),
        .ENC_MEM_DATA        (ENC_MEM_DATA),
        .SCHED_FULL          (SCHED_FULL),
        .CTRL_SCHED_EVENT_IN (CTRL_SCHED_EVENT_IN),
        .CTRL_SCHED_VIRTS    (CTRL_SCHED_VIRTS),
        .CTRL_SCHED_ADDR     (CTRL_SCHED_ADDR),
        .ENC_BUSY            (ENC_BUSY),
        .ENC_STEP_DONE       (ENC_STEP_DONE),
        .ENC_DONE            (ENC_DONE),
        .ENC_STEP            (ENC_STEP)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (ENC_MEM_CS && ENC_MEM_ADDR < AW'(NP)) ENC_MEM_DATA <= mem[ENC_MEM_ADDR];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_compared++;
        if (act != exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: per step, per pixel, spike when pixel > current low LFSR byte, then advance LFSR
    task automatic load_model();
        logic [15:0] l;
        exp_q.delete();
        l = 16'hACE1;
        for (int s = 0; s < TS; s++) begin
            for (int a = 0; a < NP; a++) begin
                if (mem[a] > l[7:0]) exp_q.push_back(s * 1024 + a);
                l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
            end
        end
        step_cnt = 0;
        done_cnt = 0;
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            if (CTRL_SCHED_EVENT_IN) begin
                chk("event_virts", int'(CTRL_SCHED_VIRTS), 0);
                chk("event_full_clear", int'(SCHED_FULL), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", int'(ENC_STEP) * 1024 + int'(CTRL_SCHED_ADDR), -1);
                end else begin
                    chk("event_step_addr", int'(ENC_STEP) * 1024 + int'(CTRL_SCHED_ADDR), exp_q.pop_front());
                end
            end
            if (ENC_STEP_DONE) step_cnt++;
            if (ENC_DONE) done_cnt++;
        end
    end

    task automatic start_image();
        ENC_START = 1'b1;
        @(posedge CLK);
        #1 ENC_START = 1'b0;
    endtask

    task automatic wait_done(input bool_start_on_done);
        bit seen;
        seen = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge CLK);
            if (ENC_BUSY) busy_cnt++;
            if (ENC_DONE) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", int'(seen), 1);
        if (bool_start_on_done) begin
            ENC_START = 1'b1;
            @(posedge CLK);
            #1 ENC_START = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge CLK);
                chk("start_on_done_ignored", int'({ENC_BUSY, ENC_MEM_CS}), 0);
            end
        end
        @(negedge CLK);
        chk("step_done_count", step_cnt, TS);
        chk("done_count", done_cnt, 1);
        chk("events_left", exp_q.size(), 0);
        chk("busy_after_done", int'(ENC_BUSY), 0);
    endtask

    initial begin
        bit seen;
        // reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs", int'({ENC_MEM_CS, ENC_MEM_ADDR, CTRL_SCHED_EVENT_IN, CTRL_SCHED_VIRTS,
                                   CTRL_SCHED_ADDR, ENC_BUSY, ENC_STEP_DONE, ENC_DONE, ENC_STEP}), 0);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // reset while stalled in PUSH on pixel 5 (seed draw 5 is 0x27, so 255 spikes)
        for (int i = 0; i < NP; i++) mem[i] = 8'd0;
        mem[5] = 8'd255;
        load_model();
        SCHED_FULL = 1'b1;
        start_image();
        repeat (22) @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        exp_q.delete();
        chk("reset_mid_push", int'({ENC_MEM_CS, ENC_MEM_ADDR, CTRL_SCHED_EVENT_IN, CTRL_SCHED_VIRTS,
                                    CTRL_SCHED_ADDR, ENC_BUSY, ENC_STEP_DONE, ENC_DONE, ENC_STEP}), 0);
        @(posedge CLK);
        #1 RST = 1'b0;
        SCHED_FULL = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1 chk("idle_after_reset", int'({ENC_BUSY, ENC_MEM_CS, CTRL_SCHED_EVENT_IN}), 0);
        end

        // backpressure: 20 stalled cycles in PUSH, then exactly one push of addr 5
        load_model();
        SCHED_FULL = 1'b1;
        start_image();
        repeat (22) @(posedge CLK);
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            chk("stall_no_event", int'(CTRL_SCHED_EVENT_IN), 0);
            chk("stall_addr_hold", int'(CTRL_SCHED_ADDR), 0);
            chk("stall_no_cs", int'(ENC_MEM_CS), 0);
            chk("stall_mem_addr", int'(ENC_MEM_ADDR), 5);
        end
        SCHED_FULL = 1'b0;
        chk("events_before_release", exp_q.size(), 2);
        wait_done(1'b0);

        // all-zero image: no events, fixed scan length, start coincident with DONE ignored
        for (int i = 0; i < NP; i++) mem[i] = 8'd0;
        load_model();
        start_image();
        wait_done(1'b1);
        chk("zero_image_busy_cycles", busy_cnt, TS * NP * 3 + TS);

        // all-255 image
        for (int i = 0; i < NP; i++) mem[i] = 8'd255;
        load_model();
        start_image();
        wait_done(1'b0);

        // random image against the reference model
        for (int i = 0; i < NP; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[0] = 8'd0;
        load_model();
        start_image();
        wait_done(1'b0);

        // step gating: no reads while READY is low, next step starts one cycle after READY
        load_model();
        CORE_STEP_READY = 1'b0;
        start_image();
        seen = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge CLK);
            if (ENC_STEP_DONE) begin
                seen = 1'b1;
                break;
            end
        end
        chk("first_step_done_seen", int'(seen), 1);
        for (int i = 0; i < 50; i++) begin
            @(posedge CLK);
            #1 chk("gated_no_cs", int'(ENC_MEM_CS), 0);
        end
        CORE_STEP_READY = 1'b1;
        @(posedge CLK);
        #1;
        chk("resume_cs", int'(ENC_MEM_CS), 1);
        chk("resume_addr", int'(ENC_MEM_ADDR), 0);
        chk("resume_step", int'(ENC_STEP), 1);
        wait_done(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
